// File: rtl/alarm_if.sv
// alarm_if: alarm controller input flags and siren/beeper/status outputs; event_count exists only under ALARM_LOG_EN.
interface alarm_if;
   logic       flag;
   logic       dooralarm;
   logic       windowalarm;
   logic       firealarm;
   logic       ack;
   logic       siren;
   logic       beeper;
   logic [2:0] alarm_state;
   logic [2:0] cause;
`ifdef ALARM_LOG_EN
   logic [7:0] event_count;
`endif
   modport master (
      output flag, dooralarm, windowalarm, firealarm, ack,
      input  siren, beeper, alarm_state, cause
`ifdef ALARM_LOG_EN
      , input event_count
`endif
   );
   modport slave (
      input  flag, dooralarm, windowalarm, firealarm, ack,
      output siren, beeper, alarm_state, cause
`ifdef ALARM_LOG_EN
      , output event_count
`endif
   );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller: siren/beeper Moore FSM with entry grace, intrusion timeout, latching fire and acknowledge.
// ALARM_LOG_EN adds a saturating count of entries into INTRUSION or FIRE.
module alarm_controller #(
   parameter int ENTRY_DELAY   = 16,
   parameter int SIREN_TIMEOUT = 64,
   parameter int BEEP_PERIOD   = 4
) (
   input logic   clock,
   input logic   reset,
   alarm_if.slave bus
);
   localparam int cnt_w = $clog2(ENTRY_DELAY > SIREN_TIMEOUT ? ENTRY_DELAY : SIREN_TIMEOUT);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ENTRY     = 3'd1,
      INTRUSION = 3'd2,
      FIRE      = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;
   state_t           state, state_next;
   logic [cnt_w-1:0] cnt, cnt_next;
   logic [2:0]       cause, cause_next, hit;
   logic             siren, beeper, siren_next, beeper_next, moved;
   int               elapsed;
   assign hit = {bus.firealarm, bus.windowalarm, bus.dooralarm};
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      state_next = bus.firealarm ? FIRE : bus.flag ? IDLE : bus.windowalarm ? INTRUSION :
                                 bus.dooralarm ? ENTRY : IDLE;
         ENTRY:     state_next = bus.firealarm ? FIRE : bus.flag ? IDLE : bus.windowalarm ? INTRUSION :
                                 cnt == '0 ? INTRUSION : ENTRY;
         INTRUSION: state_next = bus.firealarm ? FIRE : bus.flag ? IDLE :
                                 (bus.ack || cnt == '0) ? HOLDOFF : INTRUSION;
         FIRE:      state_next = (bus.ack && !bus.firealarm) ? IDLE : FIRE;
         HOLDOFF:   state_next = bus.firealarm ? FIRE :
                                 (!bus.dooralarm && !bus.windowalarm) ? IDLE : HOLDOFF;
         default:   state_next = IDLE;
      endcase
      moved = state_next != state;
      // the counter is reloaded on entry and otherwise counts down, parking at zero
      cnt_next = moved ? (state_next == ENTRY ? cnt_w'(ENTRY_DELAY - 1) :
                          state_next == INTRUSION ? cnt_w'(SIREN_TIMEOUT - 1) : cnt) :
                 ((state == ENTRY || state == INTRUSION) && cnt != '0) ? cnt - cnt_w'(1) : cnt;
      cause_next = state_next == IDLE ? 3'b000 : (moved && state_next != HOLDOFF) ? cause | hit : cause;
      elapsed = ENTRY_DELAY - 1 - int'(cnt_next);
      siren_next = state_next == INTRUSION || state_next == FIRE;
      beeper_next = state_next == FIRE || (state_next == ENTRY && (elapsed / BEEP_PERIOD) % 2 == 0);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         cause  <= '0;
         siren  <= 1'b0;
         beeper <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         cause  <= cause_next;
         siren  <= siren_next;
         beeper <= beeper_next;
      end
   end
   assign bus.alarm_state = state;
   assign bus.cause       = cause;
   assign bus.siren       = siren;
   assign bus.beeper      = beeper;
`ifdef ALARM_LOG_EN
   logic [7:0] event_count;
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         event_count <= '0;
      else if (moved && (state_next == INTRUSION || state_next == FIRE) && event_count != 8'hff)
         event_count <= event_count + 8'd1;
   end
   assign bus.event_count = event_count;
`endif
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: randomized and directed stimulus; a time-in-state reference model feeds a scoreboard
// that a negedge monitor drains against the DUT outputs.
module tb_alarm_controller;
   localparam int ENTRY_DELAY   = 16;
   localparam int SIREN_TIMEOUT = 64;
   localparam int BEEP_PERIOD   = 4;
   localparam int S_IDLE = 0, S_ENTRY = 1, S_INTR = 2, S_FIRE = 3, S_HOLD = 4;

   typedef struct {
      int st;
      int sir;
      int bp;
      int ca;
      int ev;
   } exp_t;

   logic clock;
   logic reset;
   alarm_if bus();
   alarm_controller #(
      .ENTRY_DELAY(ENTRY_DELAY),
      .SIREN_TIMEOUT(SIREN_TIMEOUT),
      .BEEP_PERIOD(BEEP_PERIOD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int   total = 0;
   int   passed = 0;
   exp_t sb[$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   // reference model: tracks how many cycles have been spent in the current state
   int   m_st, m_t, m_cause, m_ev, ns;
   logic f, fl, a, w, d;
   exp_t me;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_st = S_IDLE;
         m_t = 0;
         m_cause = 0;
         m_ev = 0;
         sb.delete();
      end else begin
         f = bus.firealarm; fl = bus.flag; a = bus.ack; w = bus.windowalarm; d = bus.dooralarm;
         ns = m_st;
         if (m_st == S_IDLE) begin
            if (f) ns = S_FIRE; else if (fl) ns = S_IDLE; else if (w) ns = S_INTR; else if (d) ns = S_ENTRY;
         end else if (m_st == S_ENTRY) begin
            if (f) ns = S_FIRE; else if (fl) ns = S_IDLE; else if (w) ns = S_INTR;
            else if (m_t >= ENTRY_DELAY) ns = S_INTR;
         end else if (m_st == S_INTR) begin
            if (f) ns = S_FIRE; else if (fl) ns = S_IDLE; else if (a || m_t >= SIREN_TIMEOUT) ns = S_HOLD;
         end else if (m_st == S_FIRE) begin
            if (a && !f) ns = S_IDLE;
         end else begin
            if (f) ns = S_FIRE; else if (!d && !w) ns = S_IDLE;
         end
         if (ns != m_st) begin
            if (ns == S_IDLE) m_cause = 0;
            else if (ns != S_HOLD) m_cause = m_cause | int'({f, w, d});
            if ((ns == S_INTR || ns == S_FIRE) && m_ev < 255) m_ev++;
            m_t = 1;
         end else if (m_t < 100000) m_t++;
         m_st = ns;
         me.st = m_st;
         me.sir = (m_st == S_INTR || m_st == S_FIRE) ? 1 : 0;
         me.bp = (m_st == S_FIRE || (m_st == S_ENTRY && ((m_t - 1) / BEEP_PERIOD) % 2 == 0)) ? 1 : 0;
         me.ca = m_cause;
         me.ev = m_ev;
         sb.push_back(me);
      end
   end

   exp_t ce;
   always @(negedge clock) begin
      if (!reset && sb.size() > 0) begin
         ce = sb.pop_front();
         chk("alarm_state", int'(bus.alarm_state), ce.st);
         chk("siren", int'(bus.siren), ce.sir);
         chk("beeper", int'(bus.beeper), ce.bp);
         chk("cause", int'(bus.cause), ce.ca);
`ifdef ALARM_LOG_EN
         chk("event_count", int'(bus.event_count), ce.ev);
`endif
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic set(input logic sf, input logic sfl, input logic sa, input logic sw, input logic sd);
      bus.firealarm = sf;
      bus.flag = sfl;
      bus.ack = sa;
      bus.windowalarm = sw;
      bus.dooralarm = sd;
   endtask

   task automatic settle();
      tick(); set(0, 1, 1, 0, 0);
      tick(); set(0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_state"}, int'(bus.alarm_state), 0);
      chk({tag, "_siren"}, int'(bus.siren), 0);
      chk({tag, "_beeper"}, int'(bus.beeper), 0);
      chk({tag, "_cause"}, int'(bus.cause), 0);
`ifdef ALARM_LOG_EN
      chk({tag, "_event_count"}, int'(bus.event_count), 0);
`endif
   endtask

   initial begin
      reset = 1'b1;
      set(0, 0, 0, 0, 0);
      #1 check_all_zero("reset");
      #11 reset = 1'b0;

      // door pulse: 16 cycles of grace with beeper 1111 0000 ..., then intrusion
      tick(); set(0, 0, 0, 0, 1);
      tick(); chk("t1_entry", int'(bus.alarm_state), S_ENTRY); chk("t1_beep_on", int'(bus.beeper), 1);
      set(0, 0, 0, 0, 0);
      repeat (4) tick();
      chk("t1_beep_off", int'(bus.beeper), 0);
      repeat (12) tick();
      chk("t1_intr", int'(bus.alarm_state), S_INTR);
      chk("t1_siren", int'(bus.siren), 1);
      chk("t1_cause", int'(bus.cause), 1);
      settle();

      // door then disarm during grace
      tick(); set(0, 0, 0, 0, 1);
      tick(); set(0, 0, 0, 0, 0);
      repeat (3) tick();
      set(0, 1, 0, 0, 0);
      tick(); chk("t2_idle", int'(bus.alarm_state), S_IDLE); chk("t2_cause", int'(bus.cause), 0);
      set(0, 0, 0, 0, 0);
      settle();

      // window held: 64 cycles of siren, then holdoff until window drops
      tick(); set(0, 0, 0, 1, 0);
      repeat (64) tick();
      chk("t3_intr_last", int'(bus.alarm_state), S_INTR);
      tick(); chk("t3_holdoff", int'(bus.alarm_state), S_HOLD); chk("t3_siren", int'(bus.siren), 0);
      set(0, 0, 0, 0, 0);
      tick(); chk("t3_idle", int'(bus.alarm_state), S_IDLE);
      settle();

      // fire ignores flag and ack while firealarm is high
      tick(); set(1, 1, 1, 0, 0);
      tick(); chk("t4_fire", int'(bus.alarm_state), S_FIRE); chk("t4_siren", int'(bus.siren), 1);
      set(1, 1, 0, 0, 0);
      repeat (3) tick();
      set(1, 1, 1, 0, 0);
      tick(); chk("t4_fire_ack", int'(bus.alarm_state), S_FIRE);
      set(0, 0, 0, 0, 0);
      tick(); chk("t4_fire_hold", int'(bus.alarm_state), S_FIRE);
      set(0, 0, 1, 0, 0);
      tick(); chk("t4_idle", int'(bus.alarm_state), S_IDLE);
      set(0, 0, 0, 0, 0);
      settle();

      // door+window then fire, then asynchronous reset mid-fire
      tick(); set(0, 0, 0, 1, 1);
      tick(); chk("t5_intr", int'(bus.alarm_state), S_INTR); chk("t5_cause011", int'(bus.cause), 3);
      set(1, 0, 0, 1, 1);
      tick(); chk("t5_fire", int'(bus.alarm_state), S_FIRE); chk("t5_cause111", int'(bus.cause), 7);
      @(posedge clock);
      #2 reset = 1'b1;
      #1 check_all_zero("t5_async");
      @(negedge clock);
      set(0, 0, 0, 0, 0);
      #2 reset = 1'b0;

`ifdef ALARM_LOG_EN
      repeat (300) begin
         tick(); set(0, 0, 0, 1, 0);
         tick(); set(0, 0, 1, 0, 0);
         tick(); set(0, 0, 0, 0, 0);
      end
      tick(); chk("t6_saturate", int'(bus.event_count), 255);
`endif

      // randomized segments: each held for a random length, ack only on the first cycle
      repeat (150) begin
         int r, len;
         logic rf, rfl, ra, rw, rd;
         r = $urandom_range(0, 99);
         rf = r < 6; rfl = ($urandom % 10) == 0; ra = ($urandom % 5) == 0;
         rw = ($urandom % 4) == 0; rd = ($urandom % 3) == 0;
         if (r >= 65) begin rf = 0; rfl = 0; rw = 0; rd = 0; end
         len = $urandom_range(1, 80);
         tick(); set(rf, rfl, ra, rw, rd);
         if (len > 1) begin
            tick(); set(rf, rfl, 0, rw, rd);
            repeat (len - 2) tick();
         end
      end
      tick(); set(0, 0, 0, 0, 0);
      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
